data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Memory-side responder for RISCVunicycle load/store requests. Word-organised data RAM
//   behind a valid/ready request channel and a valid/ready response channel. Models a fixed
//   wait-state latency so the core's stall logic is exercised. One transaction outstanding.
//   Sits between the core's load/store port and the testbench, which preloads and inspects it.
// PARAMETERS
//   DEPTH_WORDS  256           number of 32-bit words; power of two, 16..4096
//   BASE_ADDR    32'h0000_1000 byte address of word 0; aligned to DEPTH_WORDS*4
//   LATENCY      2             edges from request acceptance to response; 1..15
// PORTS
//   clock      in   1   single clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request
//   req_we     in   1   1 = store, 0 = load
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data; byte i on bits [8i+7:8i]
//   req_be     in   4   store byte enables; ignored for loads
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   core accepts response
//   rsp_rdata  out  32  load data (full word); 0 for stores and errors
//   rsp_err    out  1   access fault
// BEHAVIOUR
//   Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
//     The RAM array is not reset; its contents persist across rst.
//   FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1. Acceptance at edge E0 when req_valid&&req_ready. Register we, addr,
//     wdata, be. Load cnt=LATENCY-1. Go to WAIT.
//   WAIT: req_ready=0. Decrement cnt each edge. At the edge where cnt==0, i.e. edge
//     E0+LATENCY: perform the access, go to RESP, set rsp_valid=1.
//   Access at commit edge:
//     - err = addr[1:0]!=0 OR addr<BASE_ADDR OR addr>=BASE_ADDR+4*DEPTH_WORDS.
//     - err: no RAM change, rsp_rdata=0, rsp_err=1.
//     - Store, no err: write bytes whose be bit is 1; rsp_rdata=0. be=0 is legal, no change.
//     - Load, no err: rsp_rdata=RAM[(addr-BASE_ADDR)>>2].
//   RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
//     On that edge: rsp_valid=0, rsp_err=0, rsp_rdata=0, go to IDLE.
//     req_ready stays 0 in RESP, so a new request is never accepted on the response
//     handshake edge.
//   Throughput: with rsp_ready held at 1, the next acceptance is at E0+LATENCY+2.
//   Request inputs are ignored outside IDLE; there is no queuing.
//   Reset mid-operation: any pending request is dropped. A store is committed only if its
//     commit edge occurred before rst rose.
//   Read-after-write: a load accepted after a store's response sees the stored data.
// TESTING
//   1 Reset: rst=1 for 3 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//   2 Store then load, LATENCY=2: store addr 0x1004, data 0xDEADBEEF, be=4'hF accepted at E0
//     -> rsp_valid rises at E0+2 with rsp_err=0. Load 0x1004 -> rsp_rdata=0xDEADBEEF.
//   3 Byte enables: word 0x1008 = 0x11223344; store data 0xAABBCCDD, be=4'b0101
//     -> load returns 0x11BB33DD.
//   4 Faults: load 0x1002 -> rsp_err=1, rsp_rdata=0. Store 0x0FFC -> rsp_err=1.
//     Store 0x1400 (DEPTH 256) -> rsp_err=1. No word in RAM changes.
//   5 Back-pressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable,
//     req_ready=0 and a concurrent req_valid is not accepted. rsp_ready=1 -> IDLE next edge.
//   6 Reset mid-op: store 0x55 to 0x100C at E0, LATENCY=4, rst pulsed at E0+2
//     -> no response, word 0x100C unchanged, req_ready=1 after reset.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data RAM responder for load/store requests.
// Fixed wait-state latency, one transaction outstanding.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT0  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_commit;
    logic          w_done;
    logic          w_err;
    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_done   = (r_state == S_RESP) && rsp_ready;

    // Window and alignment check on the captured address.
    assign w_err = (r_addr[1:0] != 2'b00)
                || (r_addr < BASE_ADDR)
                || ({1'b0, r_addr} >= LIMIT);
    assign w_off = r_addr - BASE_ADDR;
    assign w_idx = AW'(w_off >> 2);

    // State and wait counter registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and wait counter sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT0;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Capture the request on acceptance so inputs may change afterwards.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Response data/error: set at commit, cleared on the response handshake.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (!w_err && !r_we) ? r_mem[w_idx] : 32'd0;
        end else if (w_done) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end
    end

    // RAM byte writes at commit; contents survive reset.
    always_ff @(posedge clock) begin
        if (w_commit && r_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed plus randomized traffic
// against a byte-level memory model.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        sel   = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be    = 4'd0;
    logic        rsp_ready = 1'b0;

    logic        rr2, rv2, re2, rr4, rv4, re4;
    logic [31:0] rd2, rd4;
    logic        w_req_ready, w_rsp_valid, w_rsp_err;
    logic [31:0] w_rsp_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mm [256];
    logic [3:0]  mk [256];

    always #5 clock = ~clock;

    data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1000), .LATENCY(2)) u_dut (
        .clock(clock), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(rr2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(re2)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1000), .LATENCY(4)) u_dut4 (
        .clock(clock), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(rr4),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_rdata(rd4), .rsp_err(re4)
    );

    assign w_req_ready = sel ? rr4 : rr2;
    assign w_rsp_valid = sel ? rv4 : rv2;
    assign w_rsp_rdata = sel ? rd4 : rd2;
    assign w_rsp_err   = sel ? re4 : re2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < 32'h1000) || (a >= 32'h1400);
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    // One full transaction; hold>0 stalls the response and pokes a new request.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rdata, output logic err);
        int cyc;
        int lat;
        logic [31:0] rd0;
        logic e0;
        lat = sel ? 4 : 2;
        chk("idle_ready", {31'd0, w_req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        cyc = 0;
        while (!w_rsp_valid && cyc < 20) begin
            chk("wait_not_ready", {31'd0, w_req_ready}, 32'd0);
            @(negedge clock);
            cyc++;
        end
        chk("latency", cyc, lat);
        rd0 = w_rsp_rdata;
        e0  = w_rsp_err;
        if (hold > 0) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h1000;
            req_be    = 4'hF;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("bp_valid", {31'd0, w_rsp_valid}, 32'd1);
            chk("bp_rdata", w_rsp_rdata, rd0);
            chk("bp_err", {31'd0, w_rsp_err}, {31'd0, e0});
            chk("bp_req_ready", {31'd0, w_req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk("hs_valid_low", {31'd0, w_rsp_valid}, 32'd0);
        chk("hs_rdata_zero", w_rsp_rdata, 32'd0);
        chk("hs_err_zero", {31'd0, w_rsp_err}, 32'd0);
        chk("hs_idle", {31'd0, w_req_ready}, 32'd1);
        @(negedge clock);
        rsp_ready = 1'b0;
        if (hold > 0) begin
            @(negedge clock);
            chk("bp_not_accepted", {30'd0, w_rsp_valid, w_req_ready}, 32'd1);
        end
        rdata = rd0;
        err   = e0;
    endtask

    // Transaction on the LATENCY=2 instance checked against the model.
    task automatic op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold);
        logic [31:0] rd;
        logic er;
        bit e;
        int idx;
        logic [31:0] m;
        txn(we, addr, wdata, be, hold, rd, er);
        e = m_err(addr);
        chk("err", {31'd0, er}, {31'd0, e});
        idx = int'((addr - 32'h1000) >> 2) & 255;
        if (e || we) begin
            chk("rdata_zero", rd, 32'd0);
        end else begin
            m = expand(mk[idx]);
            chk("load", rd & m, mm[idx] & m);
        end
        if (!e && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mm[idx][8*i +: 8] = wdata[8*i +: 8];
                    mk[idx][i] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int cyc;
        for (int i = 0; i < 256; i++) begin
            mm[i] = 32'd0;
            mk[i] = 4'd0;
        end

        rst = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", {31'd0, rr2}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rv2}, 32'd0);
        chk("rst_rdata", rd2, 32'd0);
        chk("rst_err", {31'd0, re2}, 32'd0);
        chk("rst4_state", {rd4[29:0], rr4, rv4}, 32'd2);
        rst = 1'b0;
        @(negedge clock);

        op(1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 0);
        op(1'b0, 32'h1004, 32'd0, 4'h0, 0);
        txn(1'b0, 32'h1004, 32'd0, 4'h0, 0, rd, er);
        chk("raw_direct", rd, 32'hDEADBEEF);

        op(1'b1, 32'h1008, 32'h11223344, 4'hF, 0);
        op(1'b1, 32'h1008, 32'hAABBCCDD, 4'b0101, 0);
        txn(1'b0, 32'h1008, 32'd0, 4'h0, 0, rd, er);
        chk("be_merge", rd, 32'h11BB33DD);
        op(1'b1, 32'h1008, 32'h99999999, 4'h0, 0);
        op(1'b0, 32'h1008, 32'd0, 4'h0, 0);

        op(1'b0, 32'h1002, 32'd0, 4'h0, 0);
        op(1'b1, 32'h0FFC, 32'h12345678, 4'hF, 0);
        op(1'b1, 32'h1400, 32'h12345678, 4'hF, 0);
        op(1'b1, 32'h13FC, 32'hA5A5_5A5A, 4'hF, 0);
        op(1'b0, 32'h13FC, 32'd0, 4'h0, 0);
        op(1'b1, 32'h1000, 32'h0BAD_F00D, 4'hF, 0);
        op(1'b0, 32'h1000, 32'd0, 4'h0, 0);
        op(1'b0, 32'h1004, 32'd0, 4'h0, 0);

        op(1'b0, 32'h1004, 32'd0, 4'h0, 5);
        op(1'b0, 32'h1000, 32'd0, 4'h0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int k;
            k = int'($urandom_range(0, 9));
            a = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            if (k == 0) a = a + 32'($urandom_range(1, 3));
            if (k == 1) a = 32'h1400 + (32'($urandom_range(0, 63)) << 2);
            if (k == 2) a = 32'h0F00 + (32'($urandom_range(0, 63)) << 2);
            op(1'($urandom), a, $urandom, 4'($urandom), (n % 17 == 3) ? 2 : 0);
        end

        sel = 1'b1;
        @(negedge clock);
        op(1'b1, 32'h1000, 32'd0, 4'h0, 0);
        txn(1'b1, 32'h100C, 32'hCAFEF00D, 4'hF, 0, rd, er);
        chk("d4_store_err", {31'd0, er}, 32'd0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h100C;
        req_wdata = 32'h0000_0055;
        req_be    = 4'hF;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, w_req_ready}, 32'd1);
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (w_rsp_valid) cyc++;
        end
        chk("mid_rst_no_rsp", cyc, 32'd0);
        txn(1'b0, 32'h100C, 32'd0, 4'h0, 0, rd, er);
        chk("mid_rst_unchanged", rd, 32'hCAFEF00D);
        chk("mid_rst_load_err", {31'd0, er}, 32'd0);

        sel = 1'b0;
        @(negedge clock);
        op(1'b0, 32'h1004, 32'd0, 4'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
